// File: rtl/mse_mailbox_if.sv
`timescale 1ns/1ps
// mse_mailbox_if: Avalon-MM slave port, TX/RX byte streams and IRQ line of the mailbox.
// The master modport is the host/fabric side; the slave modport is the mailbox itself.
interface mse_mailbox_if;
   logic [7:0]  avs_S1_address;
   logic [31:0] avs_S1_writedata;
   logic [3:0]  avs_S1_byteenable;
   logic        avs_S1_write;
   logic        avs_S1_read;
   logic [31:0] avs_S1_readdata;
   logic        avs_S1_readdatavalid;
   logic        avs_S1_waitrequest;
   logic [7:0]  aso_TX_data;
   logic        aso_TX_valid;
   logic        aso_TX_ready;
   logic [7:0]  asi_RX_data;
   logic        asi_RX_valid;
   logic        asi_RX_ready;
   logic        ins_IRQ_irq;

   modport master (
      output avs_S1_address, avs_S1_writedata, avs_S1_byteenable, avs_S1_write, avs_S1_read,
      input  avs_S1_readdata, avs_S1_readdatavalid, avs_S1_waitrequest,
      input  aso_TX_data, aso_TX_valid,
      output aso_TX_ready,
      output asi_RX_data, asi_RX_valid,
      input  asi_RX_ready,
      input  ins_IRQ_irq
   );

   modport slave (
      input  avs_S1_address, avs_S1_writedata, avs_S1_byteenable, avs_S1_write, avs_S1_read,
      output avs_S1_readdata, avs_S1_readdatavalid, avs_S1_waitrequest,
      output aso_TX_data, aso_TX_valid,
      input  aso_TX_ready,
      input  asi_RX_data, asi_RX_valid,
      output asi_RX_ready,
      output ins_IRQ_irq
   );
endinterface

// File: rtl/mse_mailbox.sv
`timescale 1ns/1ps
// mse_mailbox: Avalon-MM slave mailbox with a host-to-fabric TX byte FIFO and a
// fabric-to-host RX byte FIFO, status/control registers and bounded write back-pressure.
// Optional interrupt logic is built when MSE_MAILBOX_IRQ_EN is defined.
module mse_mailbox #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned WAIT_MAX   = 255
) (
   input logic          csi_MCLK_clk,
   input logic          rsi_MRST_reset_n,
   mse_mailbox_if.slave mbx
);
   localparam int unsigned Depth  = 1 << DEPTH_LOG2;
   localparam int unsigned CntW   = DEPTH_LOG2 + 1;
   localparam int unsigned StallW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   localparam logic [CntW-1:0]   CntFull    = CntW'(Depth);
   localparam logic [StallW-1:0] StallMax   = StallW'(WAIT_MAX);
   localparam logic [31:0]       IdValue    = 32'h4D53_4542;
   localparam logic [7:0]        AddrData   = 8'h00;
   localparam logic [7:0]        AddrStatus = 8'h01;
   localparam logic [7:0]        AddrCtrl   = 8'h02;
   localparam logic [7:0]        AddrId     = 8'h03;

   // FIFO storage and state
   logic [7:0]            tx_mem [Depth];
   logic [7:0]            rx_mem [Depth];
   logic [DEPTH_LOG2-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [DEPTH_LOG2-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [CntW-1:0]       tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

   // Register and bus state
   logic [StallW-1:0] stall_q, stall_d;
   logic              ovf_q, ovf_d, udf_q, udf_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              rvalid_q;

   logic        sel_data, sel_status, sel_ctrl, sel_id;
   logic        tx_full, tx_empty, rx_full, rx_empty;
   logic        wr_stall, wr_acc, rd_acc;
   logic        tx_push, tx_pop, tx_drop, tx_flush;
   logic        rx_push, rx_pop, rx_under, rx_flush;
   logic [31:0] status_w, ctrl_w, rd_mux;
   logic        unused_bits;

   assign sel_data   = (mbx.avs_S1_address == AddrData);
   assign sel_status = (mbx.avs_S1_address == AddrStatus);
   assign sel_ctrl   = (mbx.avs_S1_address == AddrCtrl);
   assign sel_id     = (mbx.avs_S1_address == AddrId);

   assign tx_full  = (tx_cnt_q == CntFull);
   assign tx_empty = (tx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == CntFull);
   assign rx_empty = (rx_cnt_q == '0);

   // A DATA write into a full TX stalls until space appears or the budget runs out;
   // tx_full is registered, so a same-cycle stream pop only frees the stall next cycle.
   assign wr_stall = mbx.avs_S1_write & sel_data & tx_full & (stall_q != StallMax);
   assign wr_acc   = mbx.avs_S1_write & ~wr_stall;
   assign rd_acc   = mbx.avs_S1_read;

   assign tx_flush = wr_acc & sel_ctrl & mbx.avs_S1_writedata[0];
   assign rx_flush = wr_acc & sel_ctrl & mbx.avs_S1_writedata[1];
   assign tx_push  = wr_acc & sel_data & ~tx_full;
   assign tx_drop  = wr_acc & sel_data & tx_full;
   assign tx_pop   = ~tx_empty & mbx.aso_TX_ready;
   assign rx_push  = mbx.asi_RX_valid & ~rx_full;
   assign rx_pop   = rd_acc & sel_data & ~rx_empty;
   assign rx_under = rd_acc & sel_data & rx_empty;

   assign mbx.avs_S1_waitrequest   = wr_stall;
   assign mbx.avs_S1_readdata      = rdata_q;
   assign mbx.avs_S1_readdatavalid = rvalid_q;
   assign mbx.aso_TX_valid         = ~tx_empty;
   assign mbx.aso_TX_data          = tx_mem[tx_rd_q];
   assign mbx.asi_RX_ready         = ~rx_full;

   assign unused_bits = ^{mbx.avs_S1_byteenable, mbx.avs_S1_writedata[31:8]};

   // TX FIFO next state; a flush wins over any same-cycle push or pop
   always_comb begin
      tx_wr_d  = tx_wr_q;
      tx_rd_d  = tx_rd_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_flush) begin
         tx_wr_d  = '0;
         tx_rd_d  = '0;
         tx_cnt_d = '0;
      end else begin
         if (tx_push) tx_wr_d = tx_wr_q + DEPTH_LOG2'(1);
         if (tx_pop)  tx_rd_d = tx_rd_q + DEPTH_LOG2'(1);
         tx_cnt_d = tx_cnt_q + CntW'(tx_push) - CntW'(tx_pop);
      end
   end

   // RX FIFO next state; a flush wins over any same-cycle push or pop
   always_comb begin
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      rx_cnt_d = rx_cnt_q;
      if (rx_flush) begin
         rx_wr_d  = '0;
         rx_rd_d  = '0;
         rx_cnt_d = '0;
      end else begin
         if (rx_push) rx_wr_d = rx_wr_q + DEPTH_LOG2'(1);
         if (rx_pop)  rx_rd_d = rx_rd_q + DEPTH_LOG2'(1);
         rx_cnt_d = rx_cnt_q + CntW'(rx_push) - CntW'(rx_pop);
      end
   end

   // Stall counter and sticky flags; a set event overrides a same-cycle W1C clear
   always_comb begin
      stall_d = wr_stall ? stall_q + StallW'(1) : '0;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      if (wr_acc & sel_status & mbx.avs_S1_writedata[4]) ovf_d = 1'b0;
      if (wr_acc & sel_status & mbx.avs_S1_writedata[5]) udf_d = 1'b0;
      if (tx_drop)  ovf_d = 1'b1;
      if (rx_under) udf_d = 1'b1;
   end

   // Read mux from pre-edge state; a DATA read sees the old RX head
   always_comb begin
      status_w = {16'h0, 8'(rx_cnt_q), 2'b00, udf_q, ovf_q, rx_empty, rx_full, tx_empty, tx_full};
      rd_mux   = '0;
      if (sel_data) begin
         rd_mux = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_q]};
      end else if (sel_status) begin
         rd_mux = status_w;
      end else if (sel_ctrl) begin
         rd_mux = ctrl_w;
      end else if (sel_id) begin
         rd_mux = IdValue;
      end
      rdata_d = rd_acc ? rd_mux : rdata_q;
   end

   // FIFO payload storage, no reset needed
   always_ff @(posedge csi_MCLK_clk) begin
      if (tx_push & ~tx_flush) tx_mem[tx_wr_q] <= mbx.avs_S1_writedata[7:0];
      if (rx_push & ~rx_flush) rx_mem[rx_wr_q] <= mbx.asi_RX_data;
   end

   // Control/status state register
   always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
      if (!rsi_MRST_reset_n) begin
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
         stall_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         tx_cnt_q <= tx_cnt_d;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         rx_cnt_q <= rx_cnt_d;
         stall_q  <= stall_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rd_acc;
      end
   end

`ifdef MSE_MAILBOX_IRQ_EN
   logic irq_en_q, irq_en_d, irq_q, irq_d;

   // IRQ computed from next-state so the line follows its cause by one cycle
   always_comb begin
      irq_en_d = irq_en_q;
      if (wr_acc & sel_ctrl) irq_en_d = mbx.avs_S1_writedata[2];
      irq_d = irq_en_d & ((rx_cnt_d != '0) | ovf_d | udf_d);
   end

   // IRQ enable and output register
   always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
      if (!rsi_MRST_reset_n) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign ctrl_w          = {29'h0, irq_en_q, 2'b00};
   assign mbx.ins_IRQ_irq = irq_q;
`else
   assign ctrl_w          = '0;
   assign mbx.ins_IRQ_irq = 1'b0;
`endif
endmodule

// File: tb/tb_mse_mailbox.sv
`timescale 1ns/1ps
// tb_mse_mailbox: table-driven register checks, directed FIFO/stall/flush sequences and a
// randomized phase compared against a queue-based model of the mailbox.
module tb_mse_mailbox;
   localparam int unsigned WaitMax = 255;
   localparam int unsigned Depth   = 16;
`ifdef MSE_MAILBOX_IRQ_EN
   localparam bit IrqBuilt = 1'b1;
`else
   localparam bit IrqBuilt = 1'b0;
`endif

   typedef logic [7:0] bq_t [$];
   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   mse_mailbox_if mbx ();

   mse_mailbox #(
      .DEPTH_LOG2(4),
      .WAIT_MAX  (WaitMax)
   ) dut (
      .csi_MCLK_clk    (clk),
      .rsi_MRST_reset_n(rst_n),
      .mbx             (mbx)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      mbx.avs_S1_address    = '0;
      mbx.avs_S1_writedata  = '0;
      mbx.avs_S1_byteenable = 4'hF;
      mbx.avs_S1_write      = 1'b0;
      mbx.avs_S1_read       = 1'b0;
      mbx.aso_TX_ready      = 1'b0;
      mbx.asi_RX_data       = '0;
      mbx.asi_RX_valid      = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the read was accepted
   task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
      mbx.avs_S1_address = a;
      mbx.avs_S1_read    = 1'b1;
      @(negedge clk);
      mbx.avs_S1_read = 1'b0;
      d = mbx.avs_S1_readdata;
      check("readdatavalid", {31'h0, mbx.avs_S1_readdatavalid}, 32'h1);
   endtask

   // Called at a negedge; holds the write through waitrequest, counts stalled cycles
   task automatic bus_write(input logic [7:0] a, input logic [31:0] d, output int stalls);
      mbx.avs_S1_address   = a;
      mbx.avs_S1_writedata = d;
      mbx.avs_S1_write     = 1'b1;
      stalls = 0;
      #1;
      while (mbx.avs_S1_waitrequest && stalls < 1000) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      if (stalls >= 1000) check("write_timeout", 32'(stalls), 32'd999);
      @(negedge clk);
      mbx.avs_S1_write = 1'b0;
   endtask

   task automatic fill_tx(input logic [7:0] base);
      int st;
      mbx.aso_TX_ready = 1'b0;
      for (int i = 0; i < Depth; i++) bus_write(8'h00, 32'(base + 8'(i)), st);
   endtask

   task automatic drain_tx(output bq_t got);
      got = {};
      mbx.aso_TX_ready = 1'b1;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (!mbx.aso_TX_valid) break;
         got.push_back(mbx.aso_TX_data);
         @(negedge clk);
      end
      mbx.aso_TX_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic cmp_q(input string name, input bq_t got, input bq_t exp);
      check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++) begin
         if (i < got.size()) check($sformatf("%s_%0d", name, i), 32'(got[i]), 32'(exp[i]));
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Randomized traffic against a queue model built from the register-map rules
   task automatic run_random(input int ncyc);
      logic [7:0]  txq [$];
      logic [7:0]  rxq [$];
      bit          ovf = 0, udf = 0, ien = 0, held = 0, pend = 0;
      bit          ew, acc, rd, wr, ftx, frx, txpop, txpush, drop, rxpush, rxpop, under;
      bit          exp_irq;
      int          stall = 0;
      logic [31:0] pexp = '0, rv;
      logic [7:0]  a;
      logic [31:0] wd;
      int          r;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         if (!held) begin
            mbx.avs_S1_write    = 1'b0;
            mbx.avs_S1_read     = 1'b0;
            mbx.avs_S1_address  = '0;
            mbx.avs_S1_writedata = '0;
            r = $urandom_range(0, 15);
            if (r < 5) begin
               mbx.avs_S1_write     = 1'b1;
               mbx.avs_S1_writedata = $urandom;
            end else if (r < 9) begin
               mbx.avs_S1_read = 1'b1;
               case ($urandom_range(0, 5))
                  0, 1:    mbx.avs_S1_address = 8'h00;
                  2:       mbx.avs_S1_address = 8'h01;
                  3:       mbx.avs_S1_address = 8'h02;
                  4:       mbx.avs_S1_address = 8'h03;
                  default: mbx.avs_S1_address = 8'h80 | 8'($urandom_range(0, 127));
               endcase
            end else if (r == 9) begin
               mbx.avs_S1_write     = 1'b1;
               mbx.avs_S1_address   = 8'h01;
               mbx.avs_S1_writedata = $urandom & 32'h30;
            end else if (r == 10 && $urandom_range(0, 3) == 0) begin
               mbx.avs_S1_write     = 1'b1;
               mbx.avs_S1_address   = 8'h02;
               mbx.avs_S1_writedata = 32'($urandom_range(0, 7));
            end
         end
         if (((cyc / 64) % 2) == 1) mbx.aso_TX_ready = ($urandom_range(0, 3) != 0);
         else                       mbx.aso_TX_ready = ($urandom_range(0, 3) == 0);
         mbx.asi_RX_valid = $urandom_range(0, 1);
         mbx.asi_RX_data  = 8'($urandom);
         #1;
         wr = mbx.avs_S1_write;
         rd = mbx.avs_S1_read;
         a  = mbx.avs_S1_address;
         wd = mbx.avs_S1_writedata;
         ew = wr && a == 8'h00 && txq.size() == Depth && stall < WaitMax;
         exp_irq = IrqBuilt && ien && (rxq.size() > 0 || ovf || udf);
         check("rnd_waitrequest", {31'h0, mbx.avs_S1_waitrequest}, {31'h0, ew});
         check("rnd_tx_valid", {31'h0, mbx.aso_TX_valid}, {31'h0, txq.size() > 0});
         if (txq.size() > 0) check("rnd_tx_data", 32'(mbx.aso_TX_data), 32'(txq[0]));
         check("rnd_rx_ready", {31'h0, mbx.asi_RX_ready}, {31'h0, rxq.size() < Depth});
         check("rnd_irq", {31'h0, mbx.ins_IRQ_irq}, {31'h0, exp_irq});
         check("rnd_rdvalid", {31'h0, mbx.avs_S1_readdatavalid}, {31'h0, pend});
         if (pend) check("rnd_readdata", mbx.avs_S1_readdata, pexp);
         if (rd) begin
            case (a)
               8'h00: rv = (rxq.size() > 0) ? 32'(rxq[0]) : 32'h0;
               8'h01: rv = {16'h0, 8'(rxq.size()), 2'b00, udf, ovf, rxq.size() == 0,
                            rxq.size() == Depth, txq.size() == 0, txq.size() == Depth};
               8'h02: rv = {29'h0, ien, 2'b00};
               8'h03: rv = 32'h4D53_4542;
               default: rv = 32'h0;
            endcase
            pexp = rv;
         end
         acc    = wr && !ew;
         ftx    = acc && a == 8'h02 && wd[0];
         frx    = acc && a == 8'h02 && wd[1];
         txpop  = txq.size() > 0 && mbx.aso_TX_ready;
         txpush = acc && a == 8'h00 && txq.size() < Depth;
         drop   = acc && a == 8'h00 && txq.size() == Depth;
         rxpush = mbx.asi_RX_valid && rxq.size() < Depth;
         rxpop  = rd && a == 8'h00 && rxq.size() > 0;
         under  = rd && a == 8'h00 && rxq.size() == 0;
         if (ftx) txq.delete();
         else begin
            if (txpop)  void'(txq.pop_front());
            if (txpush) txq.push_back(wd[7:0]);
         end
         if (frx) rxq.delete();
         else begin
            if (rxpop)  void'(rxq.pop_front());
            if (rxpush) rxq.push_back(mbx.asi_RX_data);
         end
         if (acc && a == 8'h01 && wd[4]) ovf = 1'b0;
         if (acc && a == 8'h01 && wd[5]) udf = 1'b0;
         if (drop)  ovf = 1'b1;
         if (under) udf = 1'b1;
         if (acc && a == 8'h02) ien = IrqBuilt && wd[2];
         stall = ew ? stall + 1 : 0;
         held  = ew;
         pend  = rd;
         @(negedge clk);
      end
      idle_inputs();
      #1;
      check("rnd_last_rdvalid", {31'h0, mbx.avs_S1_readdatavalid}, {31'h0, pend});
      if (pend) check("rnd_last_readdata", mbx.avs_S1_readdata, pexp);
      @(negedge clk);
   endtask

   vec_t        vecs [14];
   logic [31:0] rv;
   int          st, hi;
   bit          accepted;
   bq_t         got, expq;

   initial begin
      vecs[0]  = '{1'b0, 8'h03, 32'h0,  32'h4D53_4542};
      vecs[1]  = '{1'b0, 8'h01, 32'h0,  32'h0000_000A};
      vecs[2]  = '{1'b0, 8'h02, 32'h0,  32'h0};
      vecs[3]  = '{1'b0, 8'h40, 32'h0,  32'h0};
      vecs[4]  = '{1'b1, 8'h40, 32'hFF, 32'h0};
      vecs[5]  = '{1'b0, 8'h01, 32'h0,  32'h0000_000A};
      vecs[6]  = '{1'b0, 8'h00, 32'h0,  32'h0};
      vecs[7]  = '{1'b0, 8'h01, 32'h0,  32'h0000_002A};
      vecs[8]  = '{1'b1, 8'h01, 32'h20, 32'h0};
      vecs[9]  = '{1'b0, 8'h01, 32'h0,  32'h0000_000A};
      vecs[10] = '{1'b1, 8'h02, 32'h4,  32'h0};
      vecs[11] = '{1'b0, 8'h02, 32'h0,  IrqBuilt ? 32'h4 : 32'h0};
      vecs[12] = '{1'b1, 8'h01, 32'h30, 32'h0};
      vecs[13] = '{1'b0, 8'h01, 32'h0,  32'h0000_000A};

      idle_inputs();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_waitrequest", {31'h0, mbx.avs_S1_waitrequest}, 32'h0);
      check("rst_rdvalid", {31'h0, mbx.avs_S1_readdatavalid}, 32'h0);
      check("rst_readdata", mbx.avs_S1_readdata, 32'h0);
      check("rst_tx_valid", {31'h0, mbx.aso_TX_valid}, 32'h0);
      check("rst_rx_ready", {31'h0, mbx.asi_RX_ready}, 32'h1);
      check("rst_irq", {31'h0, mbx.ins_IRQ_irq}, 32'h0);
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata, st);
         else begin
            bus_read(vecs[i].addr, rv);
            check($sformatf("vec%0d_read", i), rv, vecs[i].exp);
         end
      end

      // TX ordering with a consumer that is always ready
      mbx.aso_TX_ready = 1'b1;
      expq = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) begin
         bus_write(8'h00, 32'(expq[i]), st);
         check($sformatf("tx_order_valid%0d", i), {31'h0, mbx.aso_TX_valid}, 32'h1);
         check($sformatf("tx_order_data%0d", i), 32'(mbx.aso_TX_data), 32'(expq[i]));
      end
      @(negedge clk);
      mbx.aso_TX_ready = 1'b0;
      check("tx_drained_valid", {31'h0, mbx.aso_TX_valid}, 32'h0);
      bus_read(8'h01, rv);
      check("tx_drained_status", rv, 32'h0000_000A);

      // Full TX, consumer wakes after 10 stalled cycles
      fill_tx(8'h60);
      bus_read(8'h01, rv);
      check("tx_full_status", rv, 32'h0000_0009);
      mbx.avs_S1_address   = 8'h00;
      mbx.avs_S1_writedata = 32'h44;
      mbx.avs_S1_write     = 1'b1;
      hi = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (mbx.avs_S1_waitrequest) hi++;
         @(negedge clk);
      end
      check("stall_hold_cycles", 32'(hi), 32'd10);
      got = {};
      accepted = 1'b0;
      mbx.aso_TX_ready = 1'b1;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (mbx.aso_TX_valid) got.push_back(mbx.aso_TX_data);
         if (mbx.avs_S1_write && !mbx.avs_S1_waitrequest) accepted = 1'b1;
         @(negedge clk);
         if (accepted) mbx.avs_S1_write = 1'b0;
         if (accepted && !mbx.aso_TX_valid) break;
      end
      mbx.aso_TX_ready = 1'b0;
      check("stall_release_accepted", {31'h0, accepted}, 32'h1);
      expq = {};
      for (int i = 0; i < Depth; i++) expq.push_back(8'h60 + 8'(i));
      expq.push_back(8'h44);
      cmp_q("stall_release_order", got, expq);
      bus_read(8'h01, rv);
      check("stall_release_status", rv, 32'h0000_000A);

      // Full TX, consumer never ready: write dropped after the stall budget
      fill_tx(8'h80);
      bus_write(8'h00, 32'h55, st);
      check("overflow_stall_cycles", 32'(st), 32'(WaitMax));
      bus_read(8'h01, rv);
      check("overflow_status", rv, 32'h0000_0019);
      drain_tx(got);
      expq = {};
      for (int i = 0; i < Depth; i++) expq.push_back(8'h80 + 8'(i));
      cmp_q("overflow_content", got, expq);
      bus_write(8'h01, 32'h10, st);
      bus_read(8'h01, rv);
      check("overflow_w1c", rv, 32'h0000_000A);

      // RX single byte, then underflow
      mbx.asi_RX_data  = 8'hA5;
      mbx.asi_RX_valid = 1'b1;
      @(negedge clk);
      mbx.asi_RX_valid = 1'b0;
      check("irq_after_push", {31'h0, mbx.ins_IRQ_irq}, {31'h0, IrqBuilt});
      bus_read(8'h00, rv);
      check("rx_pop_data", rv, 32'h0000_00A5);
      bus_read(8'h00, rv);
      check("rx_empty_data", rv, 32'h0);
      bus_read(8'h01, rv);
      check("underflow_status", rv, 32'h0000_002A);
      bus_write(8'h01, 32'h20, st);

      // Fill RX, one refused push, then flush
      for (int i = 0; i <= Depth; i++) begin
         mbx.asi_RX_data  = 8'h30 + 8'(i);
         mbx.asi_RX_valid = 1'b1;
         @(negedge clk);
      end
      mbx.asi_RX_valid = 1'b0;
      check("rx_full_ready", {31'h0, mbx.asi_RX_ready}, 32'h0);
      bus_read(8'h01, rv);
      check("rx_full_status", rv, 32'h0000_1006);
      bus_write(8'h02, 32'h2, st);
      check("rx_flush_ready", {31'h0, mbx.asi_RX_ready}, 32'h1);
      bus_read(8'h01, rv);
      check("rx_flush_status", rv, 32'h0000_000A);

      // Reset during a pending read aborts it and empties the FIFOs
      bus_write(8'h00, 32'h77, st);
      mbx.avs_S1_address = 8'h03;
      mbx.avs_S1_read    = 1'b1;
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      mbx.avs_S1_read = 1'b0;
      #1;
      check("rst_mid_rdvalid", {31'h0, mbx.avs_S1_readdatavalid}, 32'h0);
      check("rst_mid_tx_valid", {31'h0, mbx.aso_TX_valid}, 32'h0);
      do_reset();

      run_random(1500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mse_mailbox.md
# mse_mailbox

Avalon-MM slave mailbox that sits directly downstream of the external-bus-to-Avalon host bridge and is the target of its 8-bit-address master port. It holds a host-to-fabric TX FIFO and a fabric-to-host RX FIFO of bytes, each with a streaming port on the fabric side. It also provides status/control registers, bounded write back-pressure via waitrequest, and an optional interrupt.

## Interface
- DEPTH_LOG2, 4: log2 of each FIFO depth (16 entries).
- WAIT_MAX, 255: maximum cycles a TX-full write is stalled before it is dropped.
- csi_MCLK_clk  in  1  sole clock; all logic on its rising edge.
- rsi_MRST_reset_n  in  1  reset, asynchronous assert, active-low.
- avs_S1_address  in  8  word index.
- avs_S1_writedata  in  32  write data; only [7:0] is used for DATA.
- avs_S1_byteenable  in  4  accepted but ignored.
- avs_S1_write, avs_S1_read  in  1  transfer strobes.
- avs_S1_readdata  out  32  registered read data.
- avs_S1_readdatavalid  out  1  one-cycle pulse per accepted read.
- avs_S1_waitrequest  out  1  stall, combinational.
- aso_TX_data  out  8  TX FIFO head.
- aso_TX_valid  out  1  TX FIFO not empty.
- aso_TX_ready  in  1  consumer pop.
- asi_RX_data  in  8  byte pushed into the RX FIFO.
- asi_RX_valid  in  1  push request.
- asi_RX_ready  out  1  RX FIFO not full.
- ins_IRQ_irq  out  1  level interrupt.

## Operation
- Register map, by word index:
  - 0x00 DATA: write pushes writedata[7:0] into TX; read pops RX.
  - 0x01 STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] overflow (sticky), [5] underflow (sticky), [15:8] rx level, rest 0. Writing 1 to bit 4 or 5 clears it.
  - 0x02 CONTROL: [0] tx flush, [1] rx flush (both self-clearing, read 0), [2] irq_en.
  - 0x03 ID: reads 0x4D534542.
  - Other addresses: read 0, writes ignored.
- FIFOs are show-ahead: aso_TX_data is valid whenever aso_TX_valid is high. A pop occurs on aso_TX_valid & aso_TX_ready; a push occurs on asi_RX_valid & asi_RX_ready.
- Read of DATA with RX empty: returns 0, no pop, sets underflow.
- Write of DATA with TX full: waitrequest is held while a stall counter counts.
  - If space appears before the counter reaches WAIT_MAX, the write is accepted the cycle waitrequest drops.
  - If the counter reaches WAIT_MAX, waitrequest drops and the write is accepted but discarded, and overflow is set.
  - The counter clears whenever no TX-full DATA write is pending.
- Reads never stall.
- Flush: a CONTROL write with bit 0/1 set empties TX/RX on the next edge. A stream push or pop in that same cycle is discarded.
- Counters are DEPTH_LOG2+1 bits wide; pointers wrap modulo 2^DEPTH_LOG2.

## Timing
- Reset values:
  - Outputs: waitrequest 0, readdatavalid 0, readdata 0, aso_TX_valid 0, asi_RX_ready 1, ins_IRQ_irq 0.
  - Internal state: FIFOs empty, sticky bits 0, irq_en 0, stall counter 0.
- Reset asserted mid-transfer aborts it immediately; no readdatavalid follows.
- Read latency is fixed at 1: a read accepted in cycle N gives readdata and readdatavalid=1 in cycle N+1.
- Write accepted in cycle N: the TX entry is visible (aso_TX_valid) in N+1. STATUS reflects it in N+1.
- waitrequest is computed from the registered tx_full. A stream pop in the same cycle does not release the stall until the next cycle.
- Simultaneous push and pop on one FIFO in the same cycle: both happen, and the level is unchanged.
- An RX push in the same cycle as a DATA read pop: the pop returns the old head.
- The W1C clear of a sticky bit loses to a new set event in the same cycle (set wins).

## Configuration
- MSE_MAILBOX_IRQ_EN:
  - Defined: ins_IRQ_irq = irq_en & (!rx_empty | overflow | underflow), registered, so it asserts 1 cycle after the cause.
  - Undefined: ins_IRQ_irq is tied 0, CONTROL[2] is not stored and reads 0, and no IRQ logic is built.

## Test plan
- Reset, read ID -> readdatavalid on the next cycle with 0x4D534542. STATUS reads 0x0000000A.
- Host writes 0x11, 0x22, 0x33 to DATA with aso_TX_ready=1 -> aso_TX_data presents 0x11, 0x22, 0x33 in order, and tx_empty returns to 1.
- Fill TX to 16 with aso_TX_ready=0, then write 0x44 -> waitrequest high. Raise aso_TX_ready after 10 cycles -> write accepted, 0x44 is the last byte out, overflow stays 0.
- Same as above but never raise aso_TX_ready -> waitrequest drops after exactly 255 stall cycles, overflow=1, FIFO content unchanged. W1C 0x10 to STATUS -> overflow=0.
- Push 0xA5 on RX, then read DATA twice -> 0xA5, then 0 with underflow=1. With MSE_MAILBOX_IRQ_EN and irq_en=1, ins_IRQ_irq is high 1 cycle after the push.
- Fill RX to 16 -> asi_RX_ready=0, rx level 0x10. CONTROL write 0x2 -> next cycle rx_empty=1 and asi_RX_ready=1.
